// File: rtl/cmp_branch_ctrl_pkg.sv
// Shared definitions for the compare/branch controller: data width, FSM states,
// branch condition codes and the branch decision rule.
package cmp_branch_ctrl_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EVAL    = 2'b01,
    ST_RESOLVE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'b00,
    BR_EQ     = 2'b01,
    BR_ABOVE  = 2'b10,
    BR_BELOW  = 2'b11
  } br_cond_t;

  // Conditional branches are never taken until a compare has produced flags.
  function automatic logic br_eval(input br_cond_t cond, input logic zf,
                                   input logic cf, input logic valid);
    logic taken;
    taken = 1'b0;
    case (cond)
      BR_ALWAYS: taken = 1'b1;
      BR_EQ:     taken = valid & zf;
      BR_ABOVE:  taken = valid & ~zf & ~cf;
      BR_BELOW:  taken = valid & cf;
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/cmp_branch_ctrl_cmp_core.sv
// Combinational operand comparator: equality plus unsigned or two's-complement
// less-than, selected by signed_sel.
module cmp_core
  import cmp_branch_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              signed_sel,
  output logic              eq,
  output logic              lt
);

  assign eq = (a == b);
  assign lt = signed_sel ? ($signed(a) < $signed(b)) : (a < b);

endmodule

// File: rtl/cmp_branch_ctrl.sv
// Compare/branch-resolve controller with a registered flag pair (zf, cf).
// Define CMP_SIGNED_EN to add the cmp_signed input for two's-complement compares.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | ready; accepts a compare (priority) or a branch
// ST_EVAL    | compares latched operands, writes flags
// ST_RESOLVE | evaluates latched condition against flags
module cmp_branch_ctrl
  import cmp_branch_ctrl_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cmp_req,
  input  logic [DATA_W-1:0] cmp_a,
  input  logic [DATA_W-1:0] cmp_b,
`ifdef CMP_SIGNED_EN
  input  logic              cmp_signed,
`endif
  input  logic              br_req,
  input  logic [1:0]        br_cond,
  output logic              req_ready,
  output logic              cmp_done,
  output logic              zf,
  output logic              cf,
  output logic              br_done,
  output logic              br_taken,
  output logic              flags_valid
);

  state_t            state, state_nxt;
  logic              acc_cmp, acc_br;
  logic [DATA_W-1:0] a_q, b_q;
  logic              sgn_q;
  br_cond_t          cond_q;
  logic              core_eq, core_lt;

  cmp_core u_cmp_core (
    .a          (a_q),
    .b          (b_q),
    .signed_sel (sgn_q),
    .eq         (core_eq),
    .lt         (core_lt)
  );

  always_comb begin
    state_nxt = state;
    acc_cmp   = 1'b0;
    acc_br    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmp_req) begin
          acc_cmp   = 1'b1;
          state_nxt = ST_EVAL;
        end else if (br_req) begin
          acc_br    = 1'b1;
          state_nxt = ST_RESOLVE;
        end
      end
      ST_EVAL:    state_nxt = ST_IDLE;
      ST_RESOLVE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      cond_q      <= BR_ALWAYS;
      zf          <= 1'b0;
      cf          <= 1'b0;
      flags_valid <= 1'b0;
      cmp_done    <= 1'b0;
      br_done     <= 1'b0;
      br_taken    <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == ST_IDLE);
      cmp_done  <= 1'b0;
      br_done   <= 1'b0;
      br_taken  <= 1'b0;
      if (acc_cmp) begin
        a_q <= cmp_a;
        b_q <= cmp_b;
`ifdef CMP_SIGNED_EN
        sgn_q <= cmp_signed;
`else
        sgn_q <= 1'b0;
`endif
      end
      if (acc_br)
        cond_q <= br_cond_t'(br_cond);
      if (state == ST_EVAL) begin
        zf          <= core_eq;
        cf          <= core_lt;
        flags_valid <= 1'b1;
        cmp_done    <= 1'b1;
      end
      // Flags are stable here: a compare and a branch can never be in flight together.
      if (state == ST_RESOLVE) begin
        br_done  <= 1'b1;
        br_taken <= br_eval(cond_q, zf, cf, flags_valid);
      end
    end
  end

endmodule

// File: doc/cmp_branch_ctrl.md
CMP_BRANCH_CTRL -- requirements
Module: cmp_branch_ctrl

Interface
REQ-001 SHALL have ports: Clock  in  1  system clock; all state changes on posedge.
REQ-002 SHALL have ports: Reset  in  1  synchronous, active-high reset, sampled on posedge Clock.
REQ-003 SHALL have ports: cmp_req  in  1  compare request; cmp_a, cmp_b  in  16 each  unsigned operands.
REQ-004 SHALL have ports: br_req  in  1  branch-resolve request; br_cond  in  2  condition code (00 ALWAYS, 01 EQ, 10 ABOVE, 11 BELOW).
REQ-005 SHALL have ports: req_ready  out  1  high only in IDLE; a request is accepted when req_ready and the request are both high at posedge.
REQ-006 SHALL have ports: cmp_done  out  1  one-cycle pulse; zf, cf  out  1 each  flag register outputs.
REQ-007 SHALL have ports: br_done  out  1  one-cycle pulse; br_taken  out  1  branch decision, valid only with br_done.
REQ-008 SHALL have ports: flags_valid  out  1  high once any compare has completed since reset.

Function
REQ-009 SHALL use FSM states IDLE, EVAL, RESOLVE; all outputs registered.
REQ-010 SHALL, on compare accept at edge N, latch cmp_a/cmp_b and go IDLE->EVAL.
REQ-011 SHALL, in EVAL, compare latched operands and at edge N+1 write zf=(a==b), cf=(a<b), set flags_valid, pulse cmp_done and return to IDLE; flags and cmp_done are visible in cycle N+1..N+2 (two-edge latency, req_ready high again with cmp_done).
REQ-012 SHALL never set zf and cf together; a>b yields zf=0, cf=0.
REQ-013 SHALL, on branch accept at edge N, latch br_cond and go IDLE->RESOLVE; at edge N+1 pulse br_done with br_taken and return to IDLE.
REQ-014 SHALL evaluate br_taken: ALWAYS=1; EQ=zf; ABOVE=~zf&~cf; BELOW=cf; EQ/ABOVE/BELOW forced 0 when flags_valid=0.
REQ-015 SHALL give cmp_req priority when cmp_req and br_req are both high in IDLE; the branch stays pending and is accepted on the next req_ready cycle.
REQ-016 SHALL let a branch accepted in the cycle cmp_done is high use the newly written flags.
REQ-017 SHALL hold zf, cf, flags_valid unchanged across branches and idle cycles; only a compare or Reset alters them.
REQ-018 SHALL ignore requests while req_ready=0 (no queuing inside the block).
REQ-019 SHALL keep cmp_done and br_done mutually exclusive and each high for exactly one cycle per accepted request.

Reset
REQ-020 SHALL, on Reset=1 at posedge, enter IDLE and drive zf=0, cf=0, flags_valid=0, cmp_done=0, br_done=0, br_taken=0, req_ready=1 in the following cycle.
REQ-021 SHALL, on Reset during EVAL or RESOLVE, abort the operation with no done pulse and no flag update.
REQ-022 SHALL let Reset override any simultaneous request.

Configuration
REQ-023 SHALL, with CMP_SIGNED_EN defined, add input cmp_signed (1 bit, latched with operands) selecting two's-complement comparison for cf; zf unaffected.
REQ-024 SHALL, without CMP_SIGNED_EN, have no cmp_signed port and compare unsigned only.

Structure
REQ-025 SHALL take FSM state encoding, br_cond encodings and the 16-bit data width constant from the shared processor package.
REQ-026 SHALL instantiate one combinational sub-module cmp_core (operands, optional signed select -> eq, lt) used only in EVAL.

Verification
REQ-027 SHALL verify: Reset, then br_req cond=01 -> br_done after one edge, br_taken=0, flags_valid=0.
REQ-028 SHALL verify: cmp a=0x1234 b=0x1234 -> cmp_done at N+1, zf=1, cf=0; then cond=01 -> br_taken=1.
REQ-029 SHALL verify: cmp a=0x0005 b=0x0009 -> zf=0, cf=1; cond=11 -> taken=1, cond=10 -> taken=0.
REQ-030 SHALL verify: cmp_req and br_req (cond=10) high together, a=0xFFFF b=0x0001 -> compare first, branch next with taken=1.
REQ-031 SHALL verify: Reset asserted in EVAL -> no cmp_done, zf=cf=flags_valid=0, req_ready=1.
REQ-032 SHALL verify (CMP_SIGNED_EN): cmp_signed=1, a=0xFFFF b=0x0001 -> cf=1; cmp_signed=0 -> cf=0.
